fp_vector_runner: RTL and testbench

//  Synthesizable, parametrised vector sequencer for iterative start/done FP units (fpdiv, fpsqrt).

---
 rtl/fp_vector_runner.sv | 257 +++++++++++++++++++++++++
 tb/tb_fp_vector_runner.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_vector_runner.sv
// fp_vector_runner: vector sequencer for iterative start/done FP units (fpdiv, fpsqrt).
// Fetches {op1, op2, expected, flags_exp} from a synchronous vector memory, pulses
// dut_start, waits for dut_done under a timeout, then compares and counts the outcome
// and logs every failing vector.
// Optional feature macro: FP_VECTOR_RUNNER_FLAGCHK_EN. When defined, a vector also needs
// dut_flags to equal flags_exp to match, and a log_flags output is added.

module fp_vector_runner #(
    parameter int unsigned OP_W      = 32,
    parameter int unsigned RES_W     = 64,
    parameter int unsigned FLAG_W    = 5,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned START_CYC = 2,
    parameter int unsigned TIMEOUT   = 16,
    localparam int unsigned AW       = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [AW:0]       nvec,
    output logic [AW-1:0]     vec_addr,
    input  logic [3*OP_W+7:0] vec_data,
    output logic              dut_start,
    output logic [OP_W-1:0]   dut_op1,
    output logic [OP_W-1:0]   dut_op2,
    input  logic [RES_W-1:0]  dut_result,
    input  logic [FLAG_W-1:0] dut_flags,
    input  logic              dut_done,
    output logic              busy,
    output logic              finished,
    output logic [AW:0]       cur_idx,
    output logic [AW:0]       pass_cnt,
    output logic [AW:0]       err_cnt,
    output logic [AW:0]       tmo_cnt,
    output logic              log_valid,
    output logic [AW:0]       log_idx,
    output logic [RES_W-1:0]  log_result,
    output logic [OP_W-1:0]   log_expected,
`ifdef FP_VECTOR_RUNNER_FLAGCHK_EN
    output logic              log_timeout,
    output logic [FLAG_W-1:0] log_flags
`else
    output logic              log_timeout
`endif
);

    localparam int unsigned SW = $clog2(START_CYC + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    localparam logic [SW-1:0] START_LAST = SW'(START_CYC - 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [AW:0]   DEPTH_V    = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   IDX_ONE    = (AW + 1)'(1);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StFetch = 3'd1;
    localparam logic [2:0] StLoad  = 3'd2;
    localparam logic [2:0] StStart = 3'd3;
    localparam logic [2:0] StWait  = 3'd4;
    localparam logic [2:0] StCheck = 3'd5;
    localparam logic [2:0] StDone  = 3'd6;

    logic [2:0]       state_q, state_d;
    logic [AW:0]      nvec_q;
    logic [AW:0]      idx_q;
    logic [SW-1:0]    start_cnt_q;
    logic [TW-1:0]    wait_cnt_q;
    logic             timeout_q;
    logic [OP_W-1:0]  op1_q, op2_q, exp_q;
    logic [AW:0]      pass_q, err_q, tmo_q;
    logic             log_valid_q;
    logic [AW:0]      log_idx_q;
    logic [RES_W-1:0] log_result_q;
    logic [OP_W-1:0]  log_expected_q;
    logic             log_timeout_q;

    logic             run_go;
    logic [AW:0]      nvec_clamped;
    logic             last_vec;
    logic             start_last;
    logic             wait_tmo;
    logic             flags_ok;
    logic             match;

`ifdef FP_VECTOR_RUNNER_FLAGCHK_EN
    logic [7:0]        fexp_q;
    logic [FLAG_W-1:0] log_flags_q;
`else
    // Expected flags and unit flags play no part in the compare in this build.
    logic unused_flags;
    assign unused_flags = ^{dut_flags, vec_data[7:0]};
`endif

    // Run is honoured only while no pass is in flight.
    assign run_go       = run && ((state_q == StIdle) || (state_q == StDone));
    assign nvec_clamped = (nvec > DEPTH_V) ? DEPTH_V : nvec;
    assign last_vec     = ((idx_q + IDX_ONE) == nvec_q);
    assign start_last   = (start_cnt_q == START_LAST);
    assign wait_tmo     = !dut_done && (wait_cnt_q == TMO_LAST);

`ifdef FP_VECTOR_RUNNER_FLAGCHK_EN
    assign flags_ok = (dut_flags == fexp_q[FLAG_W-1:0]);
`else
    assign flags_ok = 1'b1;
`endif

    // Only the top OP_W bits of the unit result carry the value under test.
    assign match = !timeout_q && (dut_result[RES_W-1 -: OP_W] == exp_q) && flags_ok;

    // Next-state logic for the sequencing FSM.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (run_go) begin
                    state_d = (nvec_clamped == '0) ? StDone : StFetch;
                end
            end
            StFetch: state_d = StLoad;
            StLoad:  state_d = StStart;
            StStart: begin
                if (start_last) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (dut_done || wait_tmo) begin
                    state_d = StCheck;
                end
            end
            StCheck: state_d = last_vec ? StDone : StFetch;
            default: state_d = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Start-pulse and wait counters; each is cleared whenever its state is left.
    always_ff @(posedge clk) begin
        if (!reset) begin
            start_cnt_q <= '0;
            wait_cnt_q  <= '0;
            timeout_q   <= 1'b0;
        end else begin
            start_cnt_q <= (state_q == StStart) ? start_cnt_q + 1'b1 : '0;
            wait_cnt_q  <= (state_q == StWait) ? wait_cnt_q + 1'b1 : '0;
            if (state_q == StWait) begin
                timeout_q <= wait_tmo;
            end else if (state_q == StFetch) begin
                timeout_q <= 1'b0;
            end
        end
    end

    // Vector capture one cycle after the address is presented.
    always_ff @(posedge clk) begin
        if (!reset) begin
            op1_q <= '0;
            op2_q <= '0;
            exp_q <= '0;
`ifdef FP_VECTOR_RUNNER_FLAGCHK_EN
            fexp_q <= '0;
`endif
        end else if (state_q == StLoad) begin
            op1_q <= vec_data[3*OP_W+7 -: OP_W];
            op2_q <= vec_data[2*OP_W+7 -: OP_W];
            exp_q <= vec_data[OP_W+7 -: OP_W];
`ifdef FP_VECTOR_RUNNER_FLAGCHK_EN
            fexp_q <= vec_data[7:0];
`endif
        end
    end

    // Pass bookkeeping: vector count, index and result counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
            nvec_q <= '0;
            idx_q  <= '0;
            pass_q <= '0;
            err_q  <= '0;
            tmo_q  <= '0;
        end else if (run_go) begin
            nvec_q <= nvec_clamped;
            idx_q  <= '0;
            pass_q <= '0;
            err_q  <= '0;
            tmo_q  <= '0;
        end else if (state_q == StCheck) begin
            if (match) begin
                pass_q <= pass_q + IDX_ONE;
            end else begin
                err_q <= err_q + IDX_ONE;
            end
            if (timeout_q) begin
                tmo_q <= tmo_q + IDX_ONE;
            end
            // idx stays on the last vector once the pass completes.
            if (!last_vec) begin
                idx_q <= idx_q + IDX_ONE;
            end
        end
    end

    // Failure log: single-cycle valid pulse, payload held until the next failure.
    always_ff @(posedge clk) begin
        if (!reset) begin
            log_valid_q    <= 1'b0;
            log_idx_q      <= '0;
            log_result_q   <= '0;
            log_expected_q <= '0;
            log_timeout_q  <= 1'b0;
`ifdef FP_VECTOR_RUNNER_FLAGCHK_EN
            log_flags_q    <= '0;
`endif
        end else begin
            log_valid_q <= 1'b0;
            if ((state_q == StCheck) && !match) begin
                log_valid_q    <= 1'b1;
                log_idx_q      <= idx_q;
                log_result_q   <= dut_result;
                log_expected_q <= exp_q;
                log_timeout_q  <= timeout_q;
`ifdef FP_VECTOR_RUNNER_FLAGCHK_EN
                log_flags_q    <= dut_flags;
`endif
            end
        end
    end

    assign vec_addr     = idx_q[AW-1:0];
    assign dut_start    = (state_q == StStart);
    assign dut_op1      = op1_q;
    assign dut_op2      = op2_q;
    assign busy         = (state_q == StFetch) || (state_q == StLoad) || (state_q == StStart) ||
                          (state_q == StWait) || (state_q == StCheck);
    assign finished     = (state_q == StDone);
    assign cur_idx      = idx_q;
    assign pass_cnt     = pass_q;
    assign err_cnt      = err_q;
    assign tmo_cnt      = tmo_q;
    assign log_valid    = log_valid_q;
    assign log_idx      = log_idx_q;
    assign log_result   = log_result_q;
    assign log_expected = log_expected_q;
    assign log_timeout  = log_timeout_q;
`ifdef FP_VECTOR_RUNNER_FLAGCHK_EN
    assign log_flags    = log_flags_q;
`endif

endmodule

// File: tb/tb_fp_vector_runner.sv
// Testbench for fp_vector_runner: vector memory and iterative-unit models, a scoreboard of
// expected failure-log entries, and directed passes covering pass/fail/timeout/clamp/reset.

module tb_fp_vector_runner;

    localparam int OP_W   = 32;
    localparam int RES_W  = 64;
    localparam int FLAG_W = 5;
    localparam int DEPTH  = 1024;
    localparam int AW     = $clog2(DEPTH);
    localparam int VW     = 3 * OP_W + 8;

    localparam logic [31:0] HANG_OP2 = 32'hDEAD_0000;
    localparam logic [31:0] FLAG_OP2 = 32'h0000_F1A7;

`ifdef FP_VECTOR_RUNNER_FLAGCHK_EN
    localparam bit FLAGCHK = 1'b1;
`else
    localparam bit FLAGCHK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              run;
    logic [AW:0]       nvec;
    logic [AW-1:0]     vec_addr;
    logic [VW-1:0]     vec_data = '0;
    logic              dut_start;
    logic [OP_W-1:0]   dut_op1, dut_op2;
    logic [RES_W-1:0]  dut_result = '0;
    logic [FLAG_W-1:0] dut_flags = '0;
    logic              dut_done = 1'b0;
    logic              busy, finished;
    logic [AW:0]       cur_idx, pass_cnt, err_cnt, tmo_cnt;
    logic              log_valid;
    logic [AW:0]       log_idx;
    logic [RES_W-1:0]  log_result;
    logic [OP_W-1:0]   log_expected;
    logic              log_timeout;
`ifdef FP_VECTOR_RUNNER_FLAGCHK_EN
    logic [FLAG_W-1:0] log_flags;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fp_vector_runner dut (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .nvec         (nvec),
        .vec_addr     (vec_addr),
        .vec_data     (vec_data),
        .dut_start    (dut_start),
        .dut_op1      (dut_op1),
        .dut_op2      (dut_op2),
        .dut_result   (dut_result),
        .dut_flags    (dut_flags),
        .dut_done     (dut_done),
        .busy         (busy),
        .finished     (finished),
        .cur_idx      (cur_idx),
        .pass_cnt     (pass_cnt),
        .err_cnt      (err_cnt),
        .tmo_cnt      (tmo_cnt),
        .log_valid    (log_valid),
        .log_idx      (log_idx),
        .log_result   (log_result),
        .log_expected (log_expected),
`ifdef FP_VECTOR_RUNNER_FLAGCHK_EN
        .log_timeout  (log_timeout),
        .log_flags    (log_flags)
`else
        .log_timeout  (log_timeout)
`endif
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Vector memory, one-cycle read latency.
    logic [VW-1:0] mem [DEPTH];
    always @(posedge clk) vec_data <= mem[vec_addr];

    // Iterative unit model: result = {op1^op2, op2}, done after a fixed count following
    // the last start cycle; op2 == HANG_OP2 never completes; op2 == FLAG_OP2 raises flag 1.
    logic       u_act = 1'b0;
    logic [2:0] u_cnt = '0;
    always @(posedge clk) begin
        if (dut_start) begin
            u_act      <= 1'b1;
            u_cnt      <= '0;
            dut_done   <= 1'b0;
            dut_result <= '0;
            dut_flags  <= '0;
        end else if (u_act && dut_op2 != HANG_OP2) begin
            if (u_cnt == 3'd3) begin
                u_act      <= 1'b0;
                dut_done   <= 1'b1;
                dut_result <= {dut_op1 ^ dut_op2, dut_op2};
                dut_flags  <= (dut_op2 == FLAG_OP2) ? 5'd1 : 5'd0;
            end else begin
                u_cnt <= u_cnt + 3'd1;
            end
        end
    end

    typedef struct {
        int          idx;
        logic [63:0] res;
        logic [31:0] ex;
        logic        tmo;
        logic [4:0]  flg;
    } log_t;
    log_t sb[$];

    // Scoreboard: each log pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        log_t e;
        if (reset && log_valid) begin
            if (sb.size() == 0) begin
                chk("log_unexpected", log_valid, 1'b0);
            end else begin
                e = sb.pop_front();
                chk("log_idx", log_idx, e.idx);
                chk("log_result", log_result, e.res);
                chk("log_expected", log_expected, e.ex);
                chk("log_timeout", log_timeout, e.tmo);
`ifdef FP_VECTOR_RUNNER_FLAGCHK_EN
                chk("log_flags", log_flags, e.flg);
`endif
            end
        end
    end

    // Every start pulse must last exactly two cycles.
    int slen = 0;
    always @(negedge clk) begin
        if (dut_start) begin
            slen++;
        end else if (slen != 0) begin
            chk("start_len", slen, 2);
            slen = 0;
        end
    end

    task automatic set_vec(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] ex);
        mem[i] = {a, b, ex, 8'h00};
    endtask

    task automatic set_ok(input int i);
        logic [31:0] a, b;
        a = $urandom;
        b = $urandom & 32'h7FFF_FFFE;
        set_vec(i, a, b, a ^ b);
    endtask

    int exp_pass, exp_err, exp_tmo, exp_lat;

    // Reference model of a whole pass over the current memory contents.
    task automatic plan(input int n);
        int m;
        logic [31:0] a, b, ex, up;
        logic [4:0] fl;
        logic hang, fail;
        log_t e;
        m = (n > DEPTH) ? DEPTH : n;
        exp_pass = 0; exp_err = 0; exp_tmo = 0; exp_lat = 0;
        for (int i = 0; i < m; i++) begin
            a    = mem[i][VW-1 -: 32];
            b    = mem[i][VW-33 -: 32];
            ex   = mem[i][39:8];
            hang = (b == HANG_OP2);
            up   = a ^ b;
            fl   = (b == FLAG_OP2) ? 5'd1 : 5'd0;
            fail = hang || (up != ex) || (FLAGCHK && fl != mem[i][4:0]);
            exp_lat += hang ? (2 + 16 + 3) : (2 + 5 + 3);
            if (hang) exp_tmo++;
            if (fail) begin
                exp_err++;
                e.idx = i;
                e.res = hang ? 64'h0 : {up, b};
                e.ex  = ex;
                e.tmo = hang;
                e.flg = hang ? 5'd0 : fl;
                sb.push_back(e);
            end else begin
                exp_pass++;
            end
        end
    endtask

    task automatic run_pass(input int n, input string tag);
        int cyc;
        plan(n);
        @(negedge clk);
        run  = 1'b1;
        nvec = n[AW:0];
        @(negedge clk);
        run = 1'b0;
        cyc = 1;
        while (!finished && cyc < exp_lat + 100) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_finished"}, finished, 1'b1);
        chk({tag, "_latency"}, cyc - 1, exp_lat);
        chk({tag, "_pass"}, pass_cnt, exp_pass);
        chk({tag, "_err"}, err_cnt, exp_err);
        chk({tag, "_tmo"}, tmo_cnt, exp_tmo);
        chk({tag, "_busy"}, busy, 1'b0);
        @(negedge clk);
        chk({tag, "_logs_left"}, sb.size(), 0);
    endtask

    initial begin
        int cyc;
        reset = 1'b0;
        run   = 1'b0;
        nvec  = '0;
        for (int i = 0; i < DEPTH; i++) set_ok(i);
        repeat (3) @(negedge clk);
        chk("rst0_ctrl", {busy, finished, dut_start, log_valid, log_timeout, vec_addr}, '0);
        chk("rst0_cnt", {pass_cnt, err_cnt, tmo_cnt, cur_idx}, '0);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_busy", {busy, finished}, 2'b00);

        // All vectors correct.
        run_pass(3, "ok3");

        // Vector 1 returns 40000000 against expected 3F800000.
        set_vec(1, 32'h4000_0000, 32'h0, 32'h3F80_0000);
        run_pass(3, "bad1");

        // Vector 1 never completes.
        set_vec(1, 32'h0000_1234, HANG_OP2, 32'h0);
        run_pass(3, "tmo1");

        // Zero-length pass from DONE: counters clear, no busy.
        @(negedge clk);
        run  = 1'b1;
        nvec = '0;
        @(negedge clk);
        run = 1'b0;
        chk("zero_busy0", busy, 1'b0);
        @(negedge clk);
        chk("zero_busy1", busy, 1'b0);
        chk("zero_finished", finished, 1'b1);
        chk("zero_cnt", {pass_cnt, err_cnt, tmo_cnt}, '0);

        // Oversized request clamps to DEPTH.
        set_ok(1);
        run_pass(DEPTH + 5, "clamp");

        // Flag mismatch on vector 0 with a correct result.
        set_vec(0, 32'h0000_1111, FLAG_OP2, 32'h0000_1111 ^ FLAG_OP2);
        run_pass(3, "flag");

        // Reset during WAIT of vector 2.
        set_ok(0);
        @(negedge clk);
        run  = 1'b1;
        nvec = 11'd3;
        @(negedge clk);
        run = 1'b0;
        cyc = 0;
        while (!(cur_idx == 2 && dut_start) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        while (dut_start && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("pre_rst_idx", cur_idx, 2);
        chk("pre_rst_pass", pass_cnt, 2);
        chk("pre_rst_busy", busy, 1'b1);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ctrl", {busy, finished, dut_start, log_valid, log_timeout, vec_addr}, '0);
        chk("rst_cnt", {pass_cnt, err_cnt, tmo_cnt, cur_idx}, '0);
        chk("rst_log", {log_idx, log_expected}, '0);
        chk("rst_logres", log_result, '0);
        chk("rst_ops", {dut_op1, dut_op2}, '0);
        reset = 1'b1;
        run_pass(3, "rerun");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: observed no completion expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
